// File: rtl/twofish_rs_sequencer.sv
// rtl/twofish_rs_sequencer.sv - serial RS-matrix S-word generator for the Twofish key schedule
// Define TWOFISH_RS_REVERSE_EN to emit S words in h-input order (S_{K-1} lowest).
module twofish_rs_sequencer #(
  parameter int         KEY_WIDTH = 128,
  parameter logic [8:0] POLY      = 9'h14D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KEY_WIDTH-1:0]   key,
  output logic                   ready,
  output logic                   done,
  output logic                   s_valid,
  output logic [KEY_WIDTH/2-1:0] s_out
);

  localparam int K  = KEY_WIDTH / 64;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(K - 1);

  // RS matrix packed row-major; byte (row, col) sits at bit offset (row*8 + col)*8.
  localparam logic [255:0] RS_TAB = {
    64'h039EDB585A8755A4,
    64'h193DAE47C1FCA102,
    64'hE568C61EF38256A4,
    64'h9EDB585A8755A401
  };

  generate
    if (KEY_WIDTH != 128 && KEY_WIDTH != 192 && KEY_WIDTH != 256) begin : g_bad_key_width
      $error("twofish_rs_sequencer: KEY_WIDTH must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_next;
  logic [KEY_WIDTH-1:0] key_r;
  logic [2:0]      c_cnt;
  logic [IW-1:0]   i_cnt;
  logic [31:0]     acc;
  logic [7:0]      m_byte;
  logic [31:0]     term;
  logic [31:0]     word;
  logic [IW-1:0]   slot;
  logic            accept;
  logic            last_col;
  logic            last_word;

  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ POLY[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  always_comb begin
    m_byte = key_r[{i_cnt, c_cnt, 3'b000} +: 8];
    term   = '0;
    for (int j = 0; j < 4; j++) begin
      term[8*j +: 8] = gfmul(RS_TAB[{2'(j), c_cnt, 3'b000} +: 8], m_byte);
    end
    word = acc ^ term;
`ifdef TWOFISH_RS_REVERSE_EN
    slot = I_LAST - i_cnt;
`else
    slot = i_cnt;
`endif
  end

  assign accept    = start && ready;
  assign last_col  = (state == BUSY) && (c_cnt == 3'd7);
  assign last_word = last_col && (i_cnt == I_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = BUSY;
      BUSY: begin
        ready = 1'b0;
        if (last_word) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_r   <= '0;
      c_cnt   <= '0;
      i_cnt   <= '0;
      acc     <= '0;
      s_out   <= '0;
      s_valid <= 1'b0;
    end else if (accept) begin
      key_r   <= key;
      c_cnt   <= '0;
      i_cnt   <= '0;
      acc     <= '0;
      s_out   <= '0;
      s_valid <= 1'b0;
    end else if (state == BUSY) begin
      c_cnt <= c_cnt + 3'd1;
      if (last_col) begin
        // The column-7 term is folded in here, so the stored word is complete.
        acc                      <= '0;
        s_out[{slot, 5'b0} +: 32] <= word;
        i_cnt                    <= (i_cnt == I_LAST) ? '0 : i_cnt + IW'(1);
        if (last_word) s_valid <= 1'b1;
      end else begin
        acc <= word;
      end
    end
  end

endmodule
